calc_req_arbiter: RTL and testbench
===================================

# calc_req_arbiter

Two-port round-robin front end that shares one full calculator between two independent requesters. It accepts one operation at a time (function code plus X/Y operands) and launches it with a single-cycle `calc_Go`. It waits for `calc_Done` or a timeout, then returns the captured high/low result and error flag to the requester that owns the operation. It sits between the requesting logic and the full calculator control unit plus datapath.

## Interface
Parameters:
- W, 4, operand and result-half width
- TIMEOUT, 64, maximum WAIT cycles before the operation is abandoned (≥2)

Ports (reset rst, asynchronous, active-high; clock CLK):
- CLK  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- req0, req1  in  1  operation request, level
- f0, f1  in  3  function code for requester 0/1
- x0, y0, x1, y1  in  W  operands for requester 0/1
- gnt0, gnt1  out  1  one-cycle accept pulse
- rvalid0, rvalid1  out  1  one-cycle result-valid pulse
- res_h, res_l  out  W  captured result halves
- res_err  out  1  captured calculator error
- res_timeout  out  1  operation abandoned
- calc_Go  out  1  launch pulse to calculator
- calc_F  out  3  function code to calculator
- calc_X, calc_Y  out  W  operands to calculator
- calc_Done  in  1  calculator completion
- calc_OutH, calc_OutL  in  W  calculator result
- calc_Err  in  1  calculator error (e.g. divide by zero)
- busy  out  1  high in every state except IDLE
- state  out  2  current state encoding

## Operation
- States: IDLE=00, ISSUE=01, WAIT=10, RESP=11.
- **IDLE:**
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, that requester wins.
  - If both are high, the requester that is not `last` wins.
  - On the accepting edge: latch the winner's f/x/y into calc_F/calc_X/calc_Y, record `owner`, go to ISSUE.
  - calc_Done is ignored in IDLE.
- **ISSUE:**
  - calc_Go=1 and gnt[owner]=1, both for exactly this cycle.
  - Clear the wait counter.
  - Go to WAIT.
- **WAIT:**
  - calc_F/X/Y are held stable; calc_Go=0.
  - If calc_Done is sampled high: capture calc_OutH/OutL/Err into res_h/res_l/res_err, set res_timeout=0, go to RESP.
  - Otherwise, if the counter equals TIMEOUT-1: set res_h=res_l=0, res_err=0, res_timeout=1, go to RESP.
  - Otherwise, increment the counter.
- **RESP:**
  - rvalid[owner]=1 for exactly this cycle.
  - Set `last`=owner.
  - Go to IDLE.
- Result registers:
  - res_* hold their values until the next WAIT exit.
  - They are not cleared in IDLE.
- Requester contract:
  - Hold req and operands stable until gnt.
  - A req still high when the arbiter re-enters IDLE is a new request.
  - Each requester has at most one operation in flight.
- Simultaneous events:
  - calc_Done and timeout in the same cycle: Done wins, and the result is captured normally.
  - Requests arriving in ISSUE, WAIT or RESP are not lost; they are evaluated on return to IDLE.
- Reset (any state, including mid-operation):
  - state=IDLE, `last`=1 (so requester 0 wins the first tie), `owner`=0, counter=0.
  - All outputs become 0: gnt, rvalid, calc_Go, calc_F/X/Y, res_*, busy.
  - No rvalid is produced for the aborted operation.

## Timing
- Accept edge → ISSUE cycle (gnt and calc_Go) → WAIT.
- rvalid is high in the cycle after the WAIT cycle in which calc_Done is sampled.
- Overall latency: if Done is first sampled N cycles after the ISSUE cycle, rvalid occurs N+1 cycles after ISSUE.
- Timeout: with ISSUE at cycle t and no Done, WAIT occupies t+1..t+TIMEOUT and RESP is at t+TIMEOUT+1.
- Minimum spacing between two calc_Go pulses: 4 cycles (ISSUE, WAIT, RESP, IDLE).
- All outputs are registered or decoded from state only; there are no combinational paths from req or calc_Done to any output.

## Test plan
- req0 only, f0=000, x0=5, y0=3; model returns Done 6 cycles after Go with OutH=0, OutL=8 → gnt0 and calc_Go in the same cycle with calc_F=000, X=5, Y=3; rvalid0 7 cycles later with res_l=8, res_h=0, res_err=0; gnt1/rvalid1 never asserted.
- req0 and req1 held high from reset for three operations → grant order 0, 1, 0; exactly one rvalid per operation, matching its owner.
- req1, f1=011, x1=9, y1=0; model returns Done with Err=1 → rvalid1 with res_err=1, res_timeout=0.
- Model never asserts Done, TIMEOUT=64 → rvalid pulse 65 cycles after the calc_Go cycle, with res_timeout=1 and res_h=res_l=0; state returns to IDLE.
- Model asserts Done exactly in the 64th WAIT cycle → result captured, res_timeout=0.
- rst pulsed during WAIT → all outputs 0 immediately, no rvalid, state=00; a following req1 is accepted normally.

Source files
------------

// File: rtl/calc_req_arbiter.sv
// Two-port round-robin front end sharing one calculator: accepts one operation,
// launches it with calc_Go, waits for calc_Done or a timeout, returns the result to its owner.
module calc_req_arbiter #(
    parameter int unsigned W       = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         CLK,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [2:0]   f0,
    input  logic [2:0]   f1,
    input  logic [W-1:0] x0,
    input  logic [W-1:0] y0,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] y1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         rvalid0,
    output logic         rvalid1,
    output logic [W-1:0] res_h,
    output logic [W-1:0] res_l,
    output logic         res_err,
    output logic         res_timeout,
    output logic         calc_Go,
    output logic [2:0]   calc_F,
    output logic [W-1:0] calc_X,
    output logic [W-1:0] calc_Y,
    input  logic         calc_Done,
    input  logic [W-1:0] calc_OutH,
    input  logic [W-1:0] calc_OutL,
    input  logic         calc_Err,
    output logic         busy,
    output logic [1:0]   state
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      f_d;
    logic [W-1:0]    x_d, y_d;
    logic [W-1:0]    res_h_d, res_l_d;
    logic            res_err_d, res_timeout_d;
    logic            gnt0_d, gnt1_d, rvalid0_d, rvalid1_d, go_d, busy_d;
    logic            winner;

    // Tie goes to the requester that was not served last
    assign winner = (req0 && req1) ? ~last_q : req1;
    assign state  = state_q;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        f_d           = calc_F;
        x_d           = calc_X;
        y_d           = calc_Y;
        res_h_d       = res_h;
        res_l_d       = res_l;
        res_err_d     = res_err;
        res_timeout_d = res_timeout;
        gnt0_d        = 1'b0;
        gnt1_d        = 1'b0;
        rvalid0_d     = 1'b0;
        rvalid1_d     = 1'b0;
        go_d          = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = ISSUE;
                    owner_d = winner;
                    f_d     = winner ? f1 : f0;
                    x_d     = winner ? x1 : x0;
                    y_d     = winner ? y1 : y0;
                    gnt0_d  = ~winner;
                    gnt1_d  = winner;
                    go_d    = 1'b1;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Done takes priority over a timeout in the same cycle
                if (calc_Done) begin
                    res_h_d       = calc_OutH;
                    res_l_d       = calc_OutL;
                    res_err_d     = calc_Err;
                    res_timeout_d = 1'b0;
                    state_d       = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    res_h_d       = '0;
                    res_l_d       = '0;
                    res_err_d     = 1'b0;
                    res_timeout_d = 1'b1;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (state_d == RESP) begin
                    rvalid0_d = ~owner_q;
                    rvalid1_d = owner_q;
                end
            end
            RESP: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            calc_F      <= '0;
            calc_X      <= '0;
            calc_Y      <= '0;
            res_h       <= '0;
            res_l       <= '0;
            res_err     <= 1'b0;
            res_timeout <= 1'b0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            rvalid0     <= 1'b0;
            rvalid1     <= 1'b0;
            calc_Go     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            calc_F      <= f_d;
            calc_X      <= x_d;
            calc_Y      <= y_d;
            res_h       <= res_h_d;
            res_l       <= res_l_d;
            res_err     <= res_err_d;
            res_timeout <= res_timeout_d;
            gnt0        <= gnt0_d;
            gnt1        <= gnt1_d;
            rvalid0     <= rvalid0_d;
            rvalid1     <= rvalid1_d;
            calc_Go     <= go_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_calc_req_arbiter.sv
// Directed self-checking bench for calc_req_arbiter; the calculator is modelled inline
// by driving calc_Done a chosen number of cycles after calc_Go.
module tb_calc_req_arbiter;

    localparam int unsigned W = 4;

    logic         CLK, rst;
    logic         req0, req1;
    logic [2:0]   f0, f1;
    logic [W-1:0] x0, y0, x1, y1;
    logic         gnt0, gnt1, rvalid0, rvalid1;
    logic [W-1:0] res_h, res_l;
    logic         res_err, res_timeout;
    logic         calc_Go;
    logic [2:0]   calc_F;
    logic [W-1:0] calc_X, calc_Y;
    logic         calc_Done;
    logic [W-1:0] calc_OutH, calc_OutL;
    logic         calc_Err;
    logic         busy;
    logic [1:0]   state;

    int checks = 0;
    int errors = 0;

    calc_req_arbiter #(.W(W), .TIMEOUT(64)) dut (
        .CLK(CLK), .rst(rst),
        .req0(req0), .req1(req1), .f0(f0), .f1(f1),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .res_h(res_h), .res_l(res_l), .res_err(res_err), .res_timeout(res_timeout),
        .calc_Go(calc_Go), .calc_F(calc_F), .calc_X(calc_X), .calc_Y(calc_Y),
        .calc_Done(calc_Done), .calc_OutH(calc_OutH), .calc_OutL(calc_OutL),
        .calc_Err(calc_Err), .busy(busy), .state(state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pulses"}, {28'd0, gnt0, gnt1, rvalid0, rvalid1}, 32'd0);
        check({tag, "_go_busy"}, {30'd0, calc_Go, busy}, 32'd0);
        check({tag, "_calc_fxy"}, {21'd0, calc_F, calc_X, calc_Y}, 32'd0);
        check({tag, "_res"}, {22'd0, res_h, res_l, res_err, res_timeout}, 32'd0);
        check({tag, "_state"}, 32'(state), 32'd0);
    endtask

    // Waits for a grant, checks the launch, then plays the calculator and checks the response.
    // done_at: cycle after calc_Go in which calc_Done is high (<=0 means never).
    task automatic do_op(input string tag, input bit own, input bit drop,
                         input logic [2:0] ef, input logic [W-1:0] ex, input logic [W-1:0] ey,
                         input int done_at, input logic [W-1:0] oh, input logic [W-1:0] ol,
                         input logic oe, input int exp_lat,
                         input logic [W-1:0] eh, input logic [W-1:0] el,
                         input logic eerr, input logic eto);
        int n;
        int stray;
        n = 0;
        while (!(gnt0 || gnt1) && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_gnt"}, {30'd0, gnt1, gnt0}, own ? 32'd2 : 32'd1);
        check({tag, "_go_fxy"}, {20'd0, calc_Go, calc_F, calc_X, calc_Y}, {20'd0, 1'b1, ef, ex, ey});
        check({tag, "_issue_state"}, {29'd0, busy, state}, 32'd5);
        if (drop) begin
            if (own) req1 = 1'b0;
            else     req0 = 1'b0;
        end
        calc_OutH = oh;
        calc_OutL = ol;
        calc_Err  = oe;
        n = 0;
        stray = 0;
        while (n < 200) begin
            tick();
            n++;
            calc_Done = (n == done_at);
            if (gnt0 || gnt1 || calc_Go) stray++;
            if (rvalid0 || rvalid1) break;
        end
        calc_Done = 1'b0;
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_stray_gnt"}, 32'(stray), 32'd0);
        check({tag, "_rvalid"}, {30'd0, rvalid1, rvalid0}, own ? 32'd2 : 32'd1);
        check({tag, "_res"}, {22'd0, res_h, res_l, res_err, res_timeout}, {22'd0, eh, el, eerr, eto});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_all_zero("reset");
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int seen;
        rst = 1'b0;
        req0 = 0; req1 = 0; f0 = '0; f1 = '0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        calc_Done = 0; calc_OutH = '0; calc_OutL = '0; calc_Err = 0;
        #2;
        do_reset();

        // Single request from port 0, Done six cycles after Go
        f0 = 3'b000; x0 = 4'd5; y0 = 4'd3; req0 = 1'b1;
        do_op("basic", 1'b0, 1'b1, 3'b000, 4'd5, 4'd3, 6, 4'd0, 4'd8, 1'b0, 7,
              4'd0, 4'd8, 1'b0, 1'b0);

        // Both requesting from reset: round-robin 0, 1, 0
        do_reset();
        f0 = 3'b001; x0 = 4'd2; y0 = 4'd1;
        f1 = 3'b010; x1 = 4'd7; y1 = 4'd6;
        req0 = 1'b1; req1 = 1'b1;
        do_op("rr0", 1'b0, 1'b0, 3'b001, 4'd2, 4'd1, 2, 4'd1, 4'd1, 1'b0, 3,
              4'd1, 4'd1, 1'b0, 1'b0);
        do_op("rr1", 1'b1, 1'b0, 3'b010, 4'd7, 4'd6, 1, 4'd2, 4'd2, 1'b0, 2,
              4'd2, 4'd2, 1'b0, 1'b0);
        do_op("rr2", 1'b0, 1'b0, 3'b001, 4'd2, 4'd1, 3, 4'd3, 4'd3, 1'b0, 4,
              4'd3, 4'd3, 1'b0, 1'b0);
        req0 = 1'b0; req1 = 1'b0;

        // Calculator error reported on port 1
        f1 = 3'b011; x1 = 4'd9; y1 = 4'd0; req1 = 1'b1;
        do_op("err", 1'b1, 1'b1, 3'b011, 4'd9, 4'd0, 2, 4'd7, 4'hF, 1'b1, 3,
              4'd7, 4'hF, 1'b1, 1'b0);

        // No Done: abandoned after 64 WAIT cycles
        f0 = 3'b100; x0 = 4'd4; y0 = 4'd2; req0 = 1'b1;
        do_op("timeout", 1'b0, 1'b1, 3'b100, 4'd4, 4'd2, 0, 4'd9, 4'd9, 1'b1, 65,
              4'd0, 4'd0, 1'b0, 1'b1);
        tick();
        check("timeout_idle", {30'd0, busy, state[1]}, 32'd0);
        check("timeout_state", 32'(state), 32'd0);

        // Done in the last WAIT cycle beats the timeout
        f1 = 3'b101; x1 = 4'd3; y1 = 4'd3; req1 = 1'b1;
        do_op("late_done", 1'b1, 1'b1, 3'b101, 4'd3, 4'd3, 64, 4'hA, 4'h5, 1'b0, 65,
              4'hA, 4'h5, 1'b0, 1'b0);

        // Reset asserted mid-WAIT aborts the operation silently
        tick();
        f0 = 3'b110; x0 = 4'd1; y0 = 4'd1; req0 = 1'b1;
        seen = 0;
        while (!gnt0 && seen < 20) begin
            tick();
            seen++;
        end
        check("abort_gnt", 32'(gnt0), 32'd1);
        req0 = 1'b0;
        tick();
        tick();
        check("abort_in_wait", 32'(state), 32'd2);
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rvalid0 || rvalid1 || busy) seen++;
        end
        check("abort_no_rvalid", 32'(seen), 32'd0);

        f1 = 3'b111; x1 = 4'd8; y1 = 4'd2; req1 = 1'b1;
        do_op("post_reset", 1'b1, 1'b1, 3'b111, 4'd8, 4'd2, 3, 4'd0, 4'd4, 1'b0, 4,
              4'd0, 4'd4, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
